// File: rtl/pipe_stage_reg.sv
// Registered pipeline stage with valid/ready handshake, flush, and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN to add one skid entry and drive in_ready from a register.
module pipe_stage_reg #(
    parameter int DATA_W = 133,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  stall_cnt_d;

    assign in_xfer_s  = in_valid && in_ready;
    assign out_xfer_s = out_valid_q && out_ready;

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign stall_cnt = stall_cnt_q;

    // Stall counter next state: count stalled cycles, saturate at all-ones
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

`ifdef PIPE_STAGE_SKID_EN

    logic              skid_valid_q;
    logic              skid_valid_d;
    logic [DATA_W-1:0] skid_data_q;
    logic [DATA_W-1:0] skid_data_d;
    logic              in_ready_q;
    logic              in_ready_d;

    assign in_ready = in_ready_q;

    // Main/skid entry next state; an arrival during a stall parks in the skid
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = {DATA_W{1'b0}};
            skid_valid_d = 1'b0;
            skid_data_d  = {DATA_W{1'b0}};
        end else if (out_xfer_s) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
                skid_data_d  = {DATA_W{1'b0}};
            end else if (in_xfer_s) begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = {DATA_W{1'b0}};
            end
        end else if (in_xfer_s) begin
            if (out_valid_q) begin
                skid_valid_d = 1'b1;
                skid_data_d  = in_data;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = in_data;
            end
        end else begin
            out_valid_d  = out_valid_q;
            out_data_d   = out_data_q;
        end
        in_ready_d = !skid_valid_d;
    end

    // State registers; reset overrides flush and every transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= {DATA_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {DATA_W{1'b0}};
            in_ready_q   <= 1'b1;
            stall_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            in_ready_q   <= in_ready_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

`else

    assign in_ready = !out_valid_q || out_ready;

    // Single-entry next state; in_ready guarantees a load never overwrites held data
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
            out_data_d  = {DATA_W{1'b0}};
        end else if (in_xfer_s) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (out_xfer_s) begin
            out_valid_d = 1'b0;
            out_data_d  = {DATA_W{1'b0}};
        end else begin
            out_valid_d = out_valid_q;
            out_data_d  = out_data_q;
        end
    end

    // State registers; reset overrides flush and every transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomized and directed bench for pipe_stage_reg against a queue-based reference model.
module tb_pipe_stage_reg;

    localparam int DW  = 133;
    localparam int CW  = 16;
    localparam int SCW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;
    logic          flush;

    logic           in_ready;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [CW-1:0]  stall_cnt;
    logic           s_in_ready;
    logic           s_out_valid;
    logic [7:0]     s_out_data;
    logic [SCW-1:0] s_stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq[$];
    longint        m_cnt;
    longint        m_scnt;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(8), .CNT_W(SCW)) dut_small (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data[7:0]),
        .in_ready(s_in_ready), .out_valid(s_out_valid), .out_data(s_out_data),
        .out_ready(out_ready), .flush(flush), .stall_cnt(s_stall_cnt)
    );

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic model_in_ready(input logic ordy);
`ifdef PIPE_STAGE_SKID_EN
        return mq.size() < 2;
`else
        return (mq.size() == 0) || ordy;
`endif
    endfunction

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] r;
        r = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return r[DW-1:0];
    endfunction

    // One clock cycle: drive, compare against the model mid-cycle, then advance the model.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic ordy,
                        input logic fl, input logic rst);
        logic          exp_rdy;
        logic [DW-1:0] exp_data;
        logic          busy;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clk);
        busy     = mq.size() > 0;
        exp_rdy  = model_in_ready(ordy);
        exp_data = busy ? mq[0] : '0;
        check_val("out_valid",   {{(DW-1){1'b0}}, out_valid},   {{(DW-1){1'b0}}, busy});
        check_val("out_data",    out_data,                      exp_data);
        check_val("in_ready",    {{(DW-1){1'b0}}, in_ready},    {{(DW-1){1'b0}}, exp_rdy});
        check_val("stall_cnt",   DW'(stall_cnt),                DW'(m_cnt));
        check_val("s_out_valid", {{(DW-1){1'b0}}, s_out_valid}, {{(DW-1){1'b0}}, busy});
        check_val("s_out_data",  DW'(s_out_data),               DW'(exp_data[7:0]));
        check_val("s_in_ready",  {{(DW-1){1'b0}}, s_in_ready},  {{(DW-1){1'b0}}, exp_rdy});
        check_val("s_stall_cnt", DW'(s_stall_cnt),              DW'(m_scnt));
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_cnt  = 0;
            m_scnt = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            if (busy && !ordy) begin
                m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : m_cnt;
                m_scnt = (m_scnt < 15)    ? m_scnt + 1 : m_scnt;
            end
            if (busy && ordy) void'(mq.pop_front());
            if (iv && exp_rdy) mq.push_back(d);
        end
        #1;
    endtask

    initial begin
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        reset     = 1'b1;
        m_cnt     = 0;
        m_scnt    = 0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state with downstream not ready: in_ready still 1
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b0);

        // Single transfer
        step(1'b1, DW'(16'hABCD), 1'b1, 1'b0, 1'b0);
        check_val("single_valid", DW'(out_valid), DW'(1));
        check_val("single_data", out_data, DW'(16'hABCD));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("single_bubble_valid", DW'(out_valid), DW'(0));
        check_val("single_bubble_data", out_data, DW'(0));

        // Streaming 1..8
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
            check_val("stream_data", out_data, DW'(i));
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Backpressure: hold 5 for 10 stalled cycles
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, DW'(5), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, DW'(6), 1'b0, 1'b0, 1'b0);
        check_val("bp_stall10", DW'(stall_cnt), DW'(10));
        check_val("bp_hold5", out_data, DW'(5));
        check_val("bp_in_ready", DW'(in_ready), DW'(0));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

`ifdef PIPE_STAGE_SKID_EN
        // Skid ordering: 7 then 8 while stalled
        step(1'b1, DW'(7), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'(8), 1'b0, 1'b0, 1'b0);
        check_val("skid_full_ready", DW'(in_ready), DW'(0));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check_val("skid_second", out_data, DW'(8));
        check_val("skid_ready_back", DW'(in_ready), DW'(1));
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

        // Flush beats a same-cycle input
        step(1'b1, DW'(3), 1'b0, 1'b0, 1'b0);
        step(1'b1, DW'(4), 1'b0, 1'b1, 1'b0);
        check_val("flush_valid", DW'(out_valid), DW'(0));
        check_val("flush_data", out_data, DW'(0));
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Saturation of the 4-bit counter, then reset together with flush
        step(1'b1, DW'(9), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check_val("sat_small", DW'(s_stall_cnt), DW'(15));
        step(1'b1, DW'(2), 1'b0, 1'b1, 1'b1);
        check_val("rst_valid", DW'(out_valid), DW'(0));
        check_val("rst_data", out_data, DW'(0));
        check_val("rst_cnt", DW'(stall_cnt), DW'(0));
        check_val("rst_ready", DW'(in_ready), DW'(1));

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) < 7), rand_data(), ($urandom_range(0, 9) < 6),
                 ($urandom_range(0, 99) < 4), ($urandom_range(0, 99) < 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
